// File: rtl/wb_pkg.sv
// wb_pkg: Wishbone CTI codes and burst master state encoding,
// shared by the master RTL and controller-side checks.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_BUS  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_BUS  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/wb_burst_wbuf.sv
// wb_burst_wbuf: write-beat buffer, one sync write port and one
// async read port; contents are not reset.
module wb_burst_wbuf #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int IW    = 3
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone classic/incrementing-burst master driven
// from a request/stream interface, with ack timeout abort.
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 256,
  localparam int SW = DW / 8,
  localparam int LW = $clog2(MAX_BURST)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [LW-1:0] req_len_i,
  input  logic [SW-1:0] req_sel_i,
  input  logic          wdat_valid_i,
  output logic          wdat_ready_o,
  input  logic [DW-1:0] wdat_i,
  output logic          rdat_valid_o,
  output logic [DW-1:0] rdat_o,
  output logic          rdat_last_o,
  output logic          done_o,
  output logic          err_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [SW-1:0] wb_sel_o,
  output logic [2:0]    wb_cti_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i
);

  localparam int TW = $clog2(TIMEOUT);

  logic [1:0]    state, nstate;
  logic          we_q, nwe;
  logic [AW-1:0] addr_q, naddr;
  logic [LW-1:0] len_q, nlen;
  logic [LW-1:0] cnt, ncnt;
  logic [SW-1:0] sel_q, nsel;
  logic [TW-1:0] tcnt, ntcnt;
  logic          abort, nabort;
  logic          fill_we, ack, bus_n, rd_ack;
  logic [DW-1:0] buf_rd, beat_dat;
  logic [2:0]    ncti;

  assign fill_we = (state == ST_FILL) && wdat_valid_i;
  assign ack     = (state == ST_BUS) && wb_ack_i;
  assign rd_ack  = ack && !we_q;

  wb_burst_wbuf #(
    .DW(DW), .DEPTH(MAX_BURST), .IW(LW)
  ) u_wbuf (
    .clk  (wb_clk_i),
    .wen  (fill_we),
    .waddr(cnt),
    .wdata(wdat_i),
    .raddr(ncnt),
    .rdata(buf_rd)
  );

  always_comb begin
    nstate = state;
    nwe    = we_q;
    naddr  = addr_q;
    nlen   = len_q;
    nsel   = sel_q;
    ncnt   = cnt;
    ntcnt  = tcnt;
    nabort = abort;
    unique case (state)
      ST_IDLE: begin
        if (req_valid_i) begin
          nwe    = req_we_i;
          naddr  = req_addr_i;
          nlen   = req_len_i;
          nsel   = req_sel_i;
          ncnt   = '0;
          ntcnt  = '0;
          nabort = 1'b0;
          nstate = req_we_i ? ST_FILL : ST_BUS;
        end
      end
      ST_FILL: begin
        if (wdat_valid_i) begin
          if (cnt == len_q) begin
            ncnt   = '0;
            ntcnt  = '0;
            nstate = ST_BUS;
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (wb_ack_i) begin
          naddr = addr_q + AW'(SW);
          ntcnt = '0;
          if (cnt == len_q) nstate = ST_DONE;
          else ncnt = cnt + 1'b1;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          nabort = 1'b1;
          nstate = ST_DONE;
        end else begin
          ntcnt = tcnt + 1'b1;
        end
      end
      default: nstate = ST_IDLE;
    endcase
  end

  assign bus_n = (nstate == ST_BUS);
  // last fill word lands in the same edge it is first driven
  assign beat_dat = (fill_we && cnt == ncnt) ? wdat_i : buf_rd;

  always_comb begin
    ncti = CTI_INCR;
    if (nlen == '0) ncti = CTI_CLASSIC;
    else if (ncnt == nlen) ncti = CTI_EOB;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= ST_IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      sel_q        <= '0;
      cnt          <= '0;
      tcnt         <= '0;
      abort        <= 1'b0;
      req_ready_o  <= 1'b0;
      wdat_ready_o <= 1'b0;
      rdat_valid_o <= 1'b0;
      rdat_o       <= '0;
      rdat_last_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_addr_o    <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      wb_cti_o     <= '0;
    end else begin
      state        <= nstate;
      we_q         <= nwe;
      addr_q       <= naddr;
      len_q        <= nlen;
      sel_q        <= nsel;
      cnt          <= ncnt;
      tcnt         <= ntcnt;
      abort        <= nabort;
      req_ready_o  <= (nstate == ST_IDLE);
      wdat_ready_o <= (nstate == ST_FILL);
      rdat_valid_o <= rd_ack;
      rdat_last_o  <= rd_ack && (cnt == len_q);
      if (rd_ack) rdat_o <= wb_dat_i;
      done_o       <= (nstate == ST_DONE);
      err_o        <= (nstate == ST_DONE) && nabort;
      wb_cyc_o     <= bus_n;
      wb_stb_o     <= bus_n;
      wb_we_o      <= bus_n && nwe;
      wb_addr_o    <= bus_n ? naddr : '0;
      wb_sel_o     <= bus_n ? nsel : '0;
      wb_cti_o     <= bus_n ? ncti : 3'b000;
      wb_dat_o     <= (bus_n && nwe) ? beat_dat : '0;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: randomized and directed checks of the burst
// master against a beat-list reference model and a bench-side slave.
module tb_wb_burst_master;
  import wb_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_len;
  logic [3:0]  req_sel;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat;
  logic        rdat_valid, rdat_last, done, err;
  logic [31:0] rdat;
  logic        cyc, stb, we;
  logic [31:0] addr, dat_o, dat_i;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic        ack;

  int total = 0;
  int bad = 0;

  logic [31:0] wdv [8];
  logic [31:0] rdv [8];
  int          wt [8];

  always #5 clk = ~clk;

  wb_burst_master #(
    .AW(32), .DW(32), .MAX_BURST(8), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .req_sel_i   (req_sel),
    .wdat_valid_i(wdat_valid),
    .wdat_ready_o(wdat_ready),
    .wdat_i      (wdat),
    .rdat_valid_o(rdat_valid),
    .rdat_o      (rdat),
    .rdat_last_o (rdat_last),
    .done_o      (done),
    .err_o       (err),
    .wb_cyc_o    (cyc),
    .wb_stb_o    (stb),
    .wb_we_o     (we),
    .wb_addr_o   (addr),
    .wb_dat_o    (dat_o),
    .wb_sel_o    (sel),
    .wb_cti_o    (cti),
    .wb_dat_i    (dat_i),
    .wb_ack_i    (ack)
  );

  task automatic run_cmd(input logic c_we, input logic [31:0] c_addr,
                         input int len, input logic [3:0] c_sel,
                         input bit noack, input string nm);
    int i, g, beat, w, n, pulses, exp_n;
    bit a, pack, plast, in_bus, abrt;
    logic [31:0] pdat, ea, ed;
    logic [2:0] ec;
    g = 0;
    while (req_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (req_ready !== 1'b1)
      begin bad++; $display("FAIL %s req_ready got=%b want=1", nm, req_ready); end
    req_valid = 1'b1;
    req_we    = c_we;
    req_addr  = c_addr;
    req_len   = 3'(len);
    req_sel   = c_sel;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    if (c_we) begin
      i = 0;
      g = 0;
      while (i <= len && g < 100) begin
        total++;
        if (wdat_ready !== 1'b1 || cyc !== 1'b0) begin
          bad++;
          $display("FAIL %s fill wdat_ready=%b cyc=%b want 1/0", nm, wdat_ready, cyc);
        end
        wdat_valid = ($urandom_range(0, 3) != 0);
        wdat = wdat_valid ? wdv[i] : $urandom;
        @(negedge clk);
        if (wdat_valid) i++;
        g++;
      end
      wdat_valid = 1'b0;
      total++;
      if (i <= len)
        begin bad++; $display("FAIL %s fill stalled at word %0d want %0d", nm, i, len + 1); end
    end
    exp_n = 0;
    for (int k = 0; k <= len; k++) exp_n += wt[k] + 1;
    if (noack) exp_n = TO;
    beat = 0; w = 0; n = 0; pack = 0; plast = 0; pdat = 0; pulses = 0; in_bus = 1;
    while (in_bus) begin
      ea = c_addr + 32'(beat) * 32'd4;
      ec = (len == 0) ? CTI_CLASSIC : ((beat == len) ? CTI_EOB : CTI_INCR);
      ed = c_we ? wdv[beat] : 32'd0;
      total++;
      if ({cyc, stb, we} !== {2'b11, c_we})
        begin bad++; $display("FAIL %s ctl beat%0d got=%b%b%b want=11%b", nm, beat, cyc, stb, we, c_we); end
      total++;
      if (addr !== ea)
        begin bad++; $display("FAIL %s addr beat%0d got=%h want=%h", nm, beat, addr, ea); end
      total++;
      if (cti !== ec)
        begin bad++; $display("FAIL %s cti beat%0d got=%b want=%b", nm, beat, cti, ec); end
      total++;
      if (dat_o !== ed || sel !== c_sel)
        begin bad++; $display("FAIL %s dat/sel beat%0d got=%h/%h want=%h/%h", nm, beat, dat_o, sel, ed, c_sel); end
      total++;
      if ({done, req_ready, wdat_ready} !== 3'b000)
        begin bad++; $display("FAIL %s busy flags got=%b want=000", nm, {done, req_ready, wdat_ready}); end
      total++;
      if (rdat_valid !== pack)
        begin bad++; $display("FAIL %s rdat_valid got=%b want=%b", nm, rdat_valid, pack); end
      if (pack) begin
        pulses++;
        total++;
        if (rdat !== pdat || rdat_last !== plast)
          begin bad++; $display("FAIL %s rdat got=%h/%b want=%h/%b", nm, rdat, rdat_last, pdat, plast); end
      end
      a = !noack && (w >= wt[beat]);
      ack = a;
      dat_i = (a && !c_we) ? rdv[beat] : $urandom;
      pack = a && !c_we;
      pdat = rdv[beat];
      plast = (beat == len);
      @(negedge clk);
      n++;
      ack = 1'b0;
      dat_i = $urandom;
      if (a) begin
        beat++;
        w = 0;
        if (beat > len) in_bus = 0;
      end else begin
        w++;
        if (w == TO) in_bus = 0;
      end
      if (n > 400) in_bus = 0;
    end
    abrt = (beat <= len);
    total++;
    if ({cyc, stb, we, addr, dat_o, sel, cti} !== '0)
      begin bad++; $display("FAIL %s bus_idle cyc=%b addr=%h cti=%b want all 0", nm, cyc, addr, cti); end
    total++;
    if ({done, err} !== {1'b1, abrt})
      begin bad++; $display("FAIL %s done/err got=%b%b want=1%b", nm, done, err, abrt); end
    total++;
    if (rdat_valid !== pack)
      begin bad++; $display("FAIL %s final rdat_valid got=%b want=%b", nm, rdat_valid, pack); end
    if (pack) begin
      pulses++;
      total++;
      if (rdat !== pdat || rdat_last !== 1'b1)
        begin bad++; $display("FAIL %s last rdat got=%h/%b want=%h/1", nm, rdat, rdat_last, pdat); end
    end
    total++;
    if (pulses != (c_we ? 0 : beat))
      begin bad++; $display("FAIL %s rdat pulses got=%0d want=%0d", nm, pulses, c_we ? 0 : beat); end
    total++;
    if (n != exp_n)
      begin bad++; $display("FAIL %s cyc cycles got=%0d want=%0d", nm, n, exp_n); end
    @(negedge clk);
    total++;
    if ({done, rdat_valid, req_ready} !== 3'b001)
      begin bad++; $display("FAIL %s post done/rv/ready got=%b want=001", nm, {done, rdat_valid, req_ready}); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if ({cyc, stb, we, addr, dat_o, sel, cti, req_ready, wdat_ready,
         rdat_valid, rdat, rdat_last, done, err} !== '0)
      begin bad++; $display("FAIL reset outputs got nonzero ready=%b cyc=%b", req_ready, cyc); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1)
      begin bad++; $display("FAIL reset_release req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_idle_ack();
    for (int k = 0; k < 3; k++) begin
      ack = 1'b1;
      dat_i = $urandom;
      @(negedge clk);
      total++;
      if ({cyc, rdat_valid, done, req_ready} !== 4'b0001)
        begin bad++; $display("FAIL idle_ack got=%b want=0001", {cyc, rdat_valid, done, req_ready}); end
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200;
    req_len = 3'd3; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ack = 1'b0;
    total++;
    if (addr !== 32'h208 || cyc !== 1'b1)
      begin bad++; $display("FAIL rst_mid beat2 addr got=%h cyc=%b want=208/1", addr, cyc); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cyc, stb, we, addr, dat_o, sel, cti, done, req_ready} !== '0)
      begin bad++; $display("FAIL rst_mid async cyc=%b addr=%h done=%b want 0", cyc, addr, done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({req_ready, done, cyc} !== 3'b100)
      begin bad++; $display("FAIL rst_mid release got=%b want=100", {req_ready, done, cyc}); end
  endtask

  task automatic test_single_read();
    wt[0] = 1;
    rdv[0] = 32'hDEADBEEF;
    run_cmd(1'b0, 32'h100, 0, 4'hF, 1'b0, "single_read");
  endtask

  task automatic test_write4();
    for (int k = 0; k < 4; k++) begin wdv[k] = 32'(k + 1); wt[k] = 0; end
    run_cmd(1'b1, 32'h1000, 3, 4'hF, 1'b0, "write4");
  endtask

  task automatic test_read8_wait();
    for (int k = 0; k < 8; k++) begin rdv[k] = $urandom; wt[k] = 0; end
    wt[2] = 3;
    run_cmd(1'b0, 32'h4000, 7, 4'h3, 1'b0, "read8_wait");
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 8; k++) wt[k] = 0;
    run_cmd(1'b0, 32'h80, 3, 4'hF, 1'b1, "timeout");
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 2; k++) begin rdv[k] = $urandom; wt[k] = 0; end
    run_cmd(1'b0, 32'hFFFF_FFFC, 1, 4'hF, 1'b0, "wrap");
  endtask

  task automatic test_back_to_back();
    logic rw;
    int   len;
    for (int k = 0; k < 24; k++) begin
      rw = 1'($urandom);
      len = $urandom_range(0, 7);
      for (int j = 0; j < 8; j++) begin
        wdv[j] = $urandom;
        rdv[j] = $urandom;
        wt[j] = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3);
      end
      run_cmd(rw, $urandom & 32'hFFFF_FFFC, len, 4'($urandom),
              (k % 8) == 7, rw ? "rand_wr" : "rand_rd");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_len = '0; req_sel = '0;
    wdat_valid = 1'b0; wdat = '0;
    dat_i = '0; ack = 1'b0;
    for (int k = 0; k < 8; k++) begin wdv[k] = '0; rdv[k] = '0; wt[k] = 0; end
    test_reset();
    test_idle_ack();
    test_reset_mid_burst();
    test_single_read();
    test_write4();
    test_read8_wait();
    test_timeout();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Synthesizable Wishbone B3 classic/incrementing-burst master that drives the slave port of the SDRAM controller from a simple request/stream interface. It accepts a read or write command of 1..MAX_BURST beats, buffers write data, runs the bus cycle with correct CTI tagging, returns read data as a stream, and aborts on ack timeout. It is the initiator counterpart of the controller's slave port. Its bus outputs obey the team's Wishbone rules 3.00/3.10/3.25/3.35 by construction.

## Interface
- AW, 32, address width (byte address)
- DW, 32, data width; SW = DW/8 select width
- MAX_BURST, 8, max beats per command (power of two); LW = $clog2(MAX_BURST)
- TIMEOUT, 256, cycles without ack before abort (≥2)

Ports:
- wb_clk_i  in  1  single clock; all logic on rising edge
- wb_rst_ni  in  1  asynchronous, active-low reset
- req_valid_i / req_ready_o  in/out  1  command handshake
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  AW  start byte address, SW-aligned
- req_len_i  in  LW  beats minus one
- req_sel_i  in  SW  byte select applied to every beat
- wdat_valid_i / wdat_ready_o  in/out  1  write data stream handshake
- wdat_i  in  DW  write beat data, in beat order
- rdat_valid_o  out  1  read beat valid
- rdat_o  out  DW  read beat data
- rdat_last_o  out  1  marks final read beat
- done_o  out  1  one-cycle pulse at command end
- err_o  out  1  valid with done_o; 1 = timeout abort
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone control
- wb_addr_o  out  AW  | wb_dat_o  out  DW  | wb_sel_o  out  SW  | wb_cti_o  out  3
- wb_dat_i  in  DW  | wb_ack_i  in  1

## Operation
- States: IDLE, FILL, BUS, DONE.
- IDLE: req_ready_o=1; all Wishbone outputs 0. On req_valid_i, latch we/addr/len/sel; write → FILL, read → BUS.
- FILL: wdat_ready_o=1; store wdat_i into buffer slot beat_cnt on each handshake. After len+1 words → BUS. Beat counter restarts at 0.
- BUS: wb_cyc_o=wb_stb_o=1 continuously, never deasserted between beats (stb==cyc always).
  - wb_we_o = latched we; wb_sel_o = latched sel; wb_dat_o = buffer[beat_cnt] on writes, 0 on reads.
  - wb_cti_o = 000 for a single-beat command, 010 for non-final burst beats, 111 for the final burst beat.
  - Each sampled wb_ack_i advances beat_cnt and adds SW to the address; address wraps modulo 2^AW.
  - Ack after the final beat → DONE.
- Timeout counter clears on entering BUS and on every ack. When it reaches TIMEOUT-1 with no ack → DONE with err=1; remaining beats are dropped.
- DONE: single cycle; done_o=1, err_o=abort flag; all Wishbone outputs 0; → IDLE.
- wb_ack_i outside BUS is ignored.
- Read data: on each ack in BUS with we=0, rdat_o<=wb_dat_i and rdat_valid_o<=1 in the next cycle. rdat_last_o is set on the final beat. No backpressure on the read stream.

## Timing
- All outputs registered. Under reset (asynchronous, immediate), every output is 0 except req_ready_o, which is also 0. Buffer contents are not reset.
- Command accepted at edge T: a read drives wb_cyc_o/wb_stb_o high from T+1. A write goes FILL from T+1, with the first bus beat in the cycle after the last fill handshake.
- A zero-wait slave achieves one beat per cycle. An ack at edge E updates addr/cti/dat for edge E+1.
- After the final ack at E: wb_cyc_o/wb_stb_o low and outputs at default from E+1. Final rdat_valid_o, done_o and DONE state all coincide at E+1. req_ready_o returns at E+2.
- Timeout: with no acks, cyc drops and done_o/err_o pulse exactly TIMEOUT cycles after stb rose.
- wb_rst_ni low mid-burst: cyc/stb drop asynchronously with no done_o. The command is lost.
- Worst-case command latency with a zero-wait slave is 2·(len+1)+3 cycles.

## Structure
- Package wb_pkg: CTI constants (CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111) and the state enum typedef, shared with the controller's testbench assertions.
- One sub-module, wb_burst_wbuf: MAX_BURST×DW register file with one write port (fill) and one asynchronous read port (beat index), no reset.

## Test plan
- Reset mid-burst: drop wb_rst_ni during beat 2 of a 4-beat read → all wb_* outputs 0 in the same cycle; no done_o; req_ready_o=1 one cycle after release.
- Single read at 0x100: slave acks on the 2nd stb cycle with 0xDEADBEEF → cti=000 throughout; rdat_o=0xDEADBEEF with rdat_last_o=1 and done_o=1, err_o=0.
- 4-beat write at 0x1000 with data 1,2,3,4, zero-wait slave → addr 0x1000/04/08/0C; dat 1..4; cti 010,010,010,111; cyc high exactly 4 cycles.
- 8-beat read with 3 wait cycles before beat 3 → stb stays high; addr/cti hold 0x…08/010 during the waits; 8 rdat_valid_o pulses, last one flagged.
- TIMEOUT=16, slave never acks → cyc/stb drop after 16 cycles; done_o=err_o=1 for one cycle; no rdat_valid_o.
- 2-beat read at 0xFFFFFFFC → second beat addr 0x00000000 with cti 111.
